lsu_bus_adapter: RTL and testbench
==================================

Name: lsu_bus_adapter

Overview:
- Load/store adapter directly upstream of the memory/peripheral bus block. Sits between the RV32E core's execute stage and the bus.
- Converts one CPU load or store (32-bit address, funct3, store data) into a bus transaction: target address, byte count, write flag and a held start request.
- Runs the start/done handshake, sign/zero-extends load data and reports faults for illegal accesses or bus timeouts.

Parameters:
- ADDR_W, 18: bus target address width. Bit ADDR_W-1 = IO select, bit ADDR_W-2 = RAM select, low ADDR_W-2 bits = offset.
- TIMEOUT_CYCLES, 4096: maximum cycles start_request is held waiting for done. 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  1  CPU access request; sampled only when busy=0
- req_write  in  1  1=store, 0=load
- req_funct3  in  3  RV32 load/store funct3
- req_addr  in  32  byte address
- req_wdata  in  32  store data (rs2)
- busy  out  1  adapter not in IDLE
- resp_done  out  1  one-cycle completion pulse
- resp_fault  out  1  valid with resp_done; 1 = access fault or timeout
- resp_rdata  out  32  extended load data; valid with resp_done
- bus_target_address  out  ADDR_W  to bus
- bus_num_bytes  out  3  1, 2 or 4
- bus_is_write  out  1  to bus
- bus_write_value  out  32  zero-padded store data
- bus_start_request  out  1  held high until bus_request_done
- bus_request_done  in  1  from bus
- bus_fetched_value  in  32  from bus; byte at lowest address in [7:0]

Behaviour:
- Reset (clk, rst_n synchronous active-low): state=IDLE. All outputs 0; timeout counter 0. Reset mid-transaction drops bus_start_request immediately and produces no resp_done.
- Region decode on req_addr[31:28]:
  - 0x0 = flash: target = {1'b0, 1'b0, offset}
  - 0x2 = RAM: target = {1'b0, 1'b1, offset}
  - 0x4 = IO: target = {1'b1, 1'b0, offset}
  - offset = req_addr[ADDR_W-3:0]
- Fault conditions (no bus request issued):
  - any other region
  - req_addr[27:ADDR_W-2] nonzero
  - store to flash
  - illegal funct3: loads allow 000/001/010/100/101, stores allow 000/001/010
- Width: funct3[1:0]=00 gives 1 byte, 01 gives 2, 10 gives 4. Misaligned addresses are legal and not faulted (bus is byte-serial).
- Store data: SB = {24'd0, wdata[7:0]}, SH = {16'd0, wdata[15:0]}, SW = wdata.
- Load data:
  - LB sign-extends bit 7; LBU zero-extends [7:0]
  - LH sign-extends bit 15; LHU zero-extends [15:0]
  - LW passes through.
- FSM states: IDLE, REQ, RELEASE, FAULT.
  - IDLE: req_valid=1 → register all bus_* outputs. Then go to REQ with bus_start_request=1 in the next cycle, or to FAULT if decode fails. busy=1 from the cycle after acceptance.
  - REQ: bus outputs held stable. When bus_request_done=1, next cycle: bus_start_request=0, resp_done=1, resp_fault=0, resp_rdata=extended data, → RELEASE. Counter increments each REQ cycle. When it reaches TIMEOUT_CYCLES (nonzero): bus_start_request=0, resp_done=1, resp_fault=1, resp_rdata=0, → RELEASE.
  - RELEASE: bus_start_request stays 0 until bus_request_done=0 is sampled, then → IDLE. This guarantees the bus sees at least one low cycle and clears its done flag. Minimum 1 cycle.
  - FAULT: one cycle: resp_done=1, resp_fault=1 → IDLE.
- Latency:
  - Accepted load/store: resp_done = 1 cycle after the bus_request_done sample.
  - Fault: resp_done 2 cycles after acceptance.
  - IO register access (bus done one cycle after start): 3 cycles accept→resp_done.
- Output timing: resp_done is a single-cycle pulse. resp_rdata and resp_fault hold their values until the next resp_done. req_valid while busy=1 is ignored (the CPU stalls on busy).
- Simultaneous events: bus_request_done in the same cycle the timeout is reached → done wins, no fault.
- bus_* outputs are registered, not combinational from req_*.

Test Plan:
- LB from RAM: req_addr=0x2000_0010, funct3=000, bus returns 0x0000_0080 → bus_target_address=0x1_0010, bus_num_bytes=1, resp_rdata=0xFFFF_FF80, resp_fault=0.
- LHU from flash: addr 0x0000_0102, funct3=101, fetched 0x1234_8001 → num_bytes=2, resp_rdata=0x0000_8001. LW passes 0xDEAD_BEEF unchanged.
- SB to IO: addr 0x4000_0000, wdata=0xAAAA_AA05 → target=0x2_0000, bus_is_write=1, write_value=0x0000_0005. Bus done after 1 cycle → resp_done exactly 3 cycles after acceptance; start_request low while done still high.
- Faults: store to 0x0000_0000, load from 0x3000_0000, load at 0x2001_0000, funct3=011 → bus_start_request never asserts, resp_done+resp_fault 2 cycles after req.
- Timeout: TIMEOUT_CYCLES=8, bus never completes → start_request high 8 cycles, then resp_fault=1. Variant: done arrives on cycle 8 → resp_fault=0.
- Reset mid-REQ: rst_n low for 1 cycle → start_request=0, busy=0 next cycle, no resp_done; a following LW completes normally.

Source files
------------

// File: rtl/lsu_bus_adapter_if.sv
// CPU request/response and byte-serial bus handshake signals of the load/store adapter.
// The adapter connects through the slave modport; the CPU/bus environment uses master.
interface lsu_bus_adapter_if #(
    parameter int ADDR_W = 18
);
    logic              req_valid;
    logic              req_write;
    logic [2:0]        req_funct3;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              busy;
    logic              resp_done;
    logic              resp_fault;
    logic [31:0]       resp_rdata;
    logic [ADDR_W-1:0] bus_target_address;
    logic [2:0]        bus_num_bytes;
    logic              bus_is_write;
    logic [31:0]       bus_write_value;
    logic              bus_start_request;
    logic              bus_request_done;
    logic [31:0]       bus_fetched_value;

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata,
        input  bus_request_done, bus_fetched_value,
        output busy, resp_done, resp_fault, resp_rdata,
        output bus_target_address, bus_num_bytes, bus_is_write, bus_write_value,
        output bus_start_request
    );

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata,
        output bus_request_done, bus_fetched_value,
        input  busy, resp_done, resp_fault, resp_rdata,
        input  bus_target_address, bus_num_bytes, bus_is_write, bus_write_value,
        input  bus_start_request
    );
endinterface

// File: rtl/lsu_bus_adapter.sv
// Turns one RV32E load/store into a held start/done bus transaction, extends load data
// and reports decode faults or bus timeouts as a single-cycle response.
module lsu_bus_adapter #(
    parameter int ADDR_W         = 18,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                   clk,
    input  logic                   rst_n,
    lsu_bus_adapter_if.slave       io
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RELEASE, S_FAULT} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [ADDR_W-1:0] bus_target_address_q, bus_target_address_d;
    logic [2:0]        bus_num_bytes_q, bus_num_bytes_d;
    logic              bus_is_write_q, bus_is_write_d;
    logic [31:0]       bus_write_value_q, bus_write_value_d;
    logic              bus_start_request_q, bus_start_request_d;
    logic              resp_done_q, resp_done_d;
    logic              resp_fault_q, resp_fault_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    logic              timeout_hit;

    function automatic logic decode_fault(input logic wr, input logic [2:0] f3,
                                          input logic [31:0] addr);
        logic bad_region, bad_high, flash_store, bad_f3;
        bad_region  = !(addr[31:28] inside {4'h0, 4'h2, 4'h4});
        bad_high    = (addr[27:0] >> (ADDR_W - 2)) != 28'd0;
        flash_store = wr && (addr[31:28] == 4'h0);
        bad_f3      = wr ? !(f3 inside {3'b000, 3'b001, 3'b010})
                         : !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        return bad_region || bad_high || flash_store || bad_f3;
    endfunction

    // Region bits are one-hot: IO in the top bit, RAM below it, flash when both clear.
    function automatic logic [ADDR_W-1:0] decode_target(input logic [31:0] addr);
        return {addr[31:28] == 4'h4, addr[31:28] == 4'h2, addr[ADDR_W-3:0]};
    endfunction

    function automatic logic [2:0] width_bytes(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [31:0] pad_store(input logic [2:0] f3, input logic [31:0] wdata);
        case (f3[1:0])
            2'b00:   return {24'd0, wdata[7:0]};
            2'b01:   return {16'd0, wdata[15:0]};
            default: return wdata;
        endcase
    endfunction

    function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [31:0] data);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = data[7:0];
        h = data[15:0];
        case (f3)
            3'b000:  return 32'(b);
            3'b001:  return 32'(h);
            3'b100:  return {24'd0, data[7:0]};
            3'b101:  return {16'd0, data[15:0]};
            default: return data;
        endcase
    endfunction

    assign timeout_hit = TIMEOUT_EN && (cnt_q == CNT_LAST);

    always_comb begin
        state_d              = state_q;
        cnt_d                = cnt_q;
        funct3_d             = funct3_q;
        bus_target_address_d = bus_target_address_q;
        bus_num_bytes_d      = bus_num_bytes_q;
        bus_is_write_d       = bus_is_write_q;
        bus_write_value_d    = bus_write_value_q;
        bus_start_request_d  = bus_start_request_q;
        resp_done_d          = 1'b0;
        resp_fault_d         = resp_fault_q;
        resp_rdata_d         = resp_rdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (io.req_valid) begin
                    funct3_d = io.req_funct3;
                    cnt_d    = '0;
                    if (decode_fault(io.req_write, io.req_funct3, io.req_addr)) begin
                        state_d = S_FAULT;
                    end else begin
                        bus_target_address_d = decode_target(io.req_addr);
                        bus_num_bytes_d      = width_bytes(io.req_funct3);
                        bus_is_write_d       = io.req_write;
                        bus_write_value_d    = io.req_write ?
                                               pad_store(io.req_funct3, io.req_wdata) : 32'd0;
                        bus_start_request_d  = 1'b1;
                        state_d              = S_REQ;
                    end
                end
            end
            S_REQ: begin
                // A done seen in the timeout cycle still completes the access cleanly.
                if (io.bus_request_done) begin
                    bus_start_request_d = 1'b0;
                    resp_done_d         = 1'b1;
                    resp_fault_d        = 1'b0;
                    resp_rdata_d        = extend_load(funct3_q, io.bus_fetched_value);
                    state_d             = S_RELEASE;
                end else if (timeout_hit) begin
                    bus_start_request_d = 1'b0;
                    resp_done_d         = 1'b1;
                    resp_fault_d        = 1'b1;
                    resp_rdata_d        = 32'd0;
                    state_d             = S_RELEASE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RELEASE: begin
                if (!io.bus_request_done) state_d = S_IDLE;
            end
            S_FAULT: begin
                resp_done_d  = 1'b1;
                resp_fault_d = 1'b1;
                resp_rdata_d = 32'd0;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q              <= S_IDLE;
            cnt_q                <= '0;
            funct3_q             <= '0;
            bus_target_address_q <= '0;
            bus_num_bytes_q      <= '0;
            bus_is_write_q       <= 1'b0;
            bus_write_value_q    <= '0;
            bus_start_request_q  <= 1'b0;
            resp_done_q          <= 1'b0;
            resp_fault_q         <= 1'b0;
            resp_rdata_q         <= '0;
        end else begin
            state_q              <= state_d;
            cnt_q                <= cnt_d;
            funct3_q             <= funct3_d;
            bus_target_address_q <= bus_target_address_d;
            bus_num_bytes_q      <= bus_num_bytes_d;
            bus_is_write_q       <= bus_is_write_d;
            bus_write_value_q    <= bus_write_value_d;
            bus_start_request_q  <= bus_start_request_d;
            resp_done_q          <= resp_done_d;
            resp_fault_q         <= resp_fault_d;
            resp_rdata_q         <= resp_rdata_d;
        end
    end

    assign io.busy               = (state_q != S_IDLE);
    assign io.resp_done          = resp_done_q;
    assign io.resp_fault         = resp_fault_q;
    assign io.resp_rdata         = resp_rdata_q;
    assign io.bus_target_address = bus_target_address_q;
    assign io.bus_num_bytes      = bus_num_bytes_q;
    assign io.bus_is_write       = bus_is_write_q;
    assign io.bus_write_value    = bus_write_value_q;
    assign io.bus_start_request  = bus_start_request_q;
endmodule

// File: tb/tb_lsu_bus_adapter.sv
// Scoreboard bench for lsu_bus_adapter: a behavioural bus answers start requests and
// every response and bus request is compared against values predicted at issue time.
module tb_lsu_bus_adapter;
    localparam int ADDR_W = 18;
    localparam int TO     = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    lsu_bus_adapter_if #(.ADDR_W(ADDR_W)) io ();

    lsu_bus_adapter #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io)
    );

    typedef struct {
        logic        fault;
        logic [31:0] rdata;
        bit          chk_rd;
        bit          rel;
        int          lat;
        int          acc;
    } resp_t;

    typedef struct {
        logic [17:0] tgt;
        logic [2:0]  nb;
        logic        wr;
        logic [31:0] wv;
    } bus_t;

    resp_t resp_q[$];
    bus_t  bus_q[$];
    resp_t mr;
    bus_t  mb;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int rises = 0;
    int hi_cnt = 0;
    int n_resp = 0;
    logic prev_start = 1'b0;

    int          bus_delay = 1;
    bit          bus_never = 1'b0;
    logic [31:0] bus_rd    = 32'd0;
    int          bcnt      = 0;
    bit          lowseen   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    function automatic bit m_fault(input bit w, input logic [2:0] f3, input logic [31:0] a);
        logic [3:0] r;
        r = a[31:28];
        if (r != 4'h0 && r != 4'h2 && r != 4'h4) return 1'b1;
        if (a[27:16] != 12'd0) return 1'b1;
        if (w && r == 4'h0) return 1'b1;
        if (w) return !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
        return !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    endfunction

    function automatic logic [31:0] m_ext(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            3'd0:    return {{24{d[7]}}, d[7:0]};
            3'd1:    return {{16{d[15]}}, d[15:0]};
            3'd4:    return {24'd0, d[7:0]};
            3'd5:    return {16'd0, d[15:0]};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] m_wv(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            3'd0:    return {24'd0, d[7:0]};
            3'd1:    return {16'd0, d[15:0]};
            default: return d;
        endcase
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Bus: raises done bus_delay cycles after it first sees start, keeps done for one
    // cycle after start falls, then clears it.
    initial begin
        io.bus_request_done  = 1'b0;
        io.bus_fetched_value = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            if (!io.bus_start_request) begin
                bcnt = 0;
                if (io.bus_request_done && !lowseen) begin
                    lowseen = 1'b1;
                end else begin
                    io.bus_request_done = 1'b0;
                    lowseen = 1'b0;
                end
            end else if (!io.bus_request_done) begin
                bcnt++;
                if (!bus_never && bcnt == bus_delay + 1) begin
                    io.bus_request_done  = 1'b1;
                    io.bus_fetched_value = bus_rd;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (io.bus_start_request && !prev_start) begin
            rises++;
            hi_cnt = 0;
            if (bus_q.size() == 0) begin
                chk("bus_unexpected", 32'd1, 32'd0);
            end else begin
                mb = bus_q.pop_front();
                chk("bus_target", 32'(io.bus_target_address), 32'(mb.tgt));
                chk("bus_nbytes", 32'(io.bus_num_bytes), 32'(mb.nb));
                chk("bus_is_write", 32'(io.bus_is_write), 32'(mb.wr));
                chk("bus_wvalue", io.bus_write_value, mb.wv);
            end
        end
        if (io.bus_start_request) hi_cnt++;
        prev_start = io.bus_start_request;
        if (io.resp_done) begin
            n_resp++;
            if (resp_q.size() == 0) begin
                chk("done_unexpected", 32'd1, 32'd0);
            end else begin
                mr = resp_q.pop_front();
                chk("resp_fault", 32'(io.resp_fault), 32'(mr.fault));
                if (mr.chk_rd) chk("resp_rdata", io.resp_rdata, mr.rdata);
                if (mr.lat >= 0) chk("latency", 32'(cyc - mr.acc), 32'(mr.lat));
                if (mr.rel) begin
                    chk("rel_start_low", 32'(io.bus_start_request), 32'd0);
                    chk("rel_done_high", 32'(io.bus_request_done), 32'd1);
                end
            end
        end
    end

    task automatic issue(input bit w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rd, input int dly,
                         input bit never);
        int    g;
        bit    f;
        resp_t r;
        bus_t  b;
        g = 0;
        while (io.busy && g < 100) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (io.busy) chk("idle_wait", 32'd1, 32'd0);
        f = m_fault(w, f3, a);
        bus_rd    = rd;
        bus_delay = dly;
        bus_never = never;
        io.req_valid  = 1'b1;
        io.req_write  = w;
        io.req_funct3 = f3;
        io.req_addr   = a;
        io.req_wdata  = wd;
        @(posedge clk);
        #1;
        io.req_valid = 1'b0;
        io.req_addr  = $urandom;
        io.req_wdata = $urandom;
        if (!f) begin
            b.tgt = {a[31:28] == 4'h4, a[31:28] == 4'h2, a[15:0]};
            b.nb  = (f3[1:0] == 2'b00) ? 3'd1 : (f3[1:0] == 2'b01) ? 3'd2 : 3'd4;
            b.wr  = w;
            b.wv  = w ? m_wv(f3, wd) : 32'd0;
            bus_q.push_back(b);
        end
        r.fault  = f || never;
        r.rdata  = (f || never) ? 32'd0 : m_ext(f3, rd);
        r.chk_rd = !w || f || never;
        r.rel    = !f && !never;
        r.lat    = f ? 2 : never ? TO + 1 : dly + 2;
        r.acc    = cyc - 1;
        resp_q.push_back(r);
        chk("busy_after_accept", 32'(io.busy), 32'd1);
    endtask

    task automatic wait_resp(input int n0);
        int g;
        g = 0;
        while (n_resp == n0 && g < 100) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (n_resp == n0) begin
            chk("resp_wait", 32'd0, 32'd1);
            resp_q.delete();
        end
    endtask

    task automatic do_req(input bit w, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rd, input int dly,
                          input bit never);
        int n0;
        n0 = n_resp;
        issue(w, f3, a, wd, rd, dly, never);
        wait_resp(n0);
    endtask

    task automatic fault_req(input bit w, input logic [2:0] f3, input logic [31:0] a);
        int r0;
        r0 = rises;
        do_req(w, f3, a, 32'h1234_5678, 32'd0, 1, 1'b0);
        chk("fault_no_start", 32'(rises), 32'(r0));
    endtask

    initial begin
        int n0;
        rst_n         = 1'b0;
        io.req_valid  = 1'b0;
        io.req_write  = 1'b0;
        io.req_funct3 = 3'd0;
        io.req_addr   = 32'd0;
        io.req_wdata  = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(io.busy), 32'd0);
        chk("rst_done", 32'(io.resp_done), 32'd0);
        chk("rst_fault", 32'(io.resp_fault), 32'd0);
        chk("rst_rdata", io.resp_rdata, 32'd0);
        chk("rst_start", 32'(io.bus_start_request), 32'd0);
        chk("rst_target", 32'(io.bus_target_address), 32'd0);
        chk("rst_nbytes", 32'(io.bus_num_bytes), 32'd0);
        chk("rst_is_write", 32'(io.bus_is_write), 32'd0);
        chk("rst_wvalue", io.bus_write_value, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Loads: sign/zero extension, misaligned addresses, varying bus delay.
        do_req(1'b0, 3'b000, 32'h2000_0010, 32'd0, 32'h0000_0080, 1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("rdata_hold", io.resp_rdata, 32'hFFFF_FF80);
        do_req(1'b0, 3'b101, 32'h0000_0102, 32'd0, 32'h1234_8001, 3, 1'b0);
        do_req(1'b0, 3'b010, 32'h2000_0004, 32'd0, 32'hDEAD_BEEF, 2, 1'b0);
        do_req(1'b0, 3'b001, 32'h4000_0101, 32'd0, 32'h0000_9ABC, 1, 1'b0);
        do_req(1'b0, 3'b100, 32'h0000_0003, 32'd0, 32'h7777_77FF, 4, 1'b0);
        do_req(1'b0, 3'b010, 32'h2000_FFFF, 32'd0, 32'h0102_0304, 0, 1'b0);

        // Stores: byte/half/word padding, IO register access.
        do_req(1'b1, 3'b000, 32'h4000_0000, 32'hAAAA_AA05, 32'd0, 1, 1'b0);
        do_req(1'b1, 3'b001, 32'h2000_0100, 32'h1234_5678, 32'd0, 2, 1'b0);
        do_req(1'b1, 3'b010, 32'h2000_0200, 32'hCAFE_F00D, 32'd0, 1, 1'b0);

        // Decode faults: no bus request, response two cycles after acceptance.
        fault_req(1'b1, 3'b010, 32'h0000_0000);
        fault_req(1'b0, 3'b010, 32'h3000_0000);
        fault_req(1'b0, 3'b010, 32'h2001_0000);
        fault_req(1'b0, 3'b011, 32'h2000_0000);
        fault_req(1'b1, 3'b100, 32'h2000_0000);

        // Timeout, then done arriving in the very cycle the timeout would fire.
        do_req(1'b0, 3'b010, 32'h2000_0040, 32'd0, 32'hFFFF_FFFF, 1, 1'b1);
        chk("timeout_start_cycles", 32'(hi_cnt), 32'(TO));
        do_req(1'b0, 3'b010, 32'h2000_0044, 32'd0, 32'h5555_AAAA, TO - 1, 1'b0);
        chk("late_done_start_cycles", 32'(hi_cnt), 32'(TO));

        // Reset while waiting on the bus.
        n0 = n_resp;
        issue(1'b0, 3'b010, 32'h2000_0048, 32'd0, 32'h0, 1, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_mid_start", 32'(io.bus_start_request), 32'd0);
        chk("rst_mid_busy", 32'(io.busy), 32'd0);
        resp_q.delete();
        repeat (12) @(posedge clk);
        #1;
        chk("rst_mid_no_done", 32'(n_resp), 32'(n0));
        do_req(1'b0, 3'b010, 32'h2000_0050, 32'd0, 32'h1357_9BDF, 1, 1'b0);

        repeat (4) @(posedge clk);
        #1;
        chk("queues_empty", 32'(resp_q.size() + bus_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
